// File: rtl/next_pc_redirect_arbiter.sv
// rtl/next_pc_redirect_arbiter.sv - fetch PC write-port sequencer and redirect arbiter
//
// Owns the single PC register write port. After rstStart it walks the
// predictor/BTB tables (initBusy/initIndex), writes the boot PC once, then
// every cycle picks the next PC: interrupt > lowest mispredicted branch lane >
// pending buffer > prediction > sequential increment.
//
// Ports:
//   clk, rst (async, active-low), rstStart (start table init)
//   stall                          fetch cannot take a new PC this cycle
//   pcOut                          current PC register value
//   brValid/brMispred/brTarget/brHistory  per-lane branch results
//   interruptAddrWE/interruptAddrIn       interrupt redirect
//   predValid/predNextPC           taken prediction
//   pcWE/pcIn                      PC register write port
//   recoverBrHistory/recoveredBrHistory   history recovery on branch writes
//   initBusy/initIndex             table init walk
//   fetchValid                     fetch may issue the current PC
module next_pc_redirect_arbiter #(
    parameter int              ISSUE_WIDTH  = 2,
    parameter int              PC_WIDTH     = 32,
    parameter int              HIST_WIDTH   = 10,
    parameter int              INIT_CYCLES  = 1024,
    parameter logic [31:0]     RESET_VECTOR = 32'h0000_1000,
    parameter int              FETCH_BYTES  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rstStart,
    input  logic                              stall,
    input  logic [PC_WIDTH-1:0]               pcOut,
    input  logic [ISSUE_WIDTH-1:0]            brValid,
    input  logic [ISSUE_WIDTH-1:0]            brMispred,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   brTarget,
    input  logic [ISSUE_WIDTH*HIST_WIDTH-1:0] brHistory,
    input  logic                              interruptAddrWE,
    input  logic [PC_WIDTH-1:0]               interruptAddrIn,
    input  logic                              predValid,
    input  logic [PC_WIDTH-1:0]               predNextPC,
    output logic                              pcWE,
    output logic [PC_WIDTH-1:0]               pcIn,
    output logic                              recoverBrHistory,
    output logic [HIST_WIDTH-1:0]             recoveredBrHistory,
    output logic                              initBusy,
    output logic [$clog2(INIT_CYCLES)-1:0]    initIndex,
    output logic                              fetchValid
);

    localparam int IDX_W = $clog2(INIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_BOOT = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic KIND_BR  = 1'b0;
    localparam logic KIND_INT = 1'b1;

    logic [1:0]            state;
    logic [IDX_W-1:0]      counter;

    logic                  pend_valid;
    logic                  pend_kind;
    logic [PC_WIDTH-1:0]   pend_pc;
    logic [HIST_WIDTH-1:0] pend_hist;

    logic                  br_hit;
    logic [PC_WIDTH-1:0]   br_pc;
    logic [HIST_WIDTH-1:0] br_hist;

    logic                  sel_rec;
    logic [PC_WIDTH-1:0]   sel_pc;
    logic [HIST_WIDTH-1:0] sel_hist;

    // Lowest mispredicted lane wins: scan from the top so lower lanes overwrite.
    always_comb begin
        br_hit  = 1'b0;
        br_pc   = '0;
        br_hist = '0;
        for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
            if (brValid[i] && brMispred[i]) begin
                br_hit  = 1'b1;
                br_pc   = brTarget[i*PC_WIDTH +: PC_WIDTH];
                br_hist = brHistory[i*HIST_WIDTH +: HIST_WIDTH];
            end
        end
    end

    always_comb begin
        sel_rec  = 1'b0;
        sel_hist = '0;
        if (interruptAddrWE) begin
            sel_pc = interruptAddrIn;
        end else if (br_hit) begin
            sel_pc   = br_pc;
            sel_rec  = 1'b1;
            sel_hist = br_hist;
        end else if (pend_valid) begin
            sel_pc   = pend_pc;
            sel_rec  = (pend_kind == KIND_BR);
            sel_hist = (pend_kind == KIND_BR) ? pend_hist : '0;
        end else if (predValid) begin
            sel_pc = predNextPC;
        end else begin
            sel_pc = pcOut + PC_WIDTH'(FETCH_BYTES);
        end
    end

    // Write port is combinational; rstStart suppresses any write in its cycle.
    always_comb begin
        pcWE               = 1'b0;
        pcIn               = '0;
        recoverBrHistory   = 1'b0;
        recoveredBrHistory = '0;
        if (!rstStart) begin
            if (state == S_BOOT) begin
                pcWE = 1'b1;
                pcIn = RESET_VECTOR[PC_WIDTH-1:0];
            end else if (state == S_RUN && !stall) begin
                pcWE               = 1'b1;
                pcIn               = sel_pc;
                recoverBrHistory   = sel_rec;
                recoveredBrHistory = sel_hist;
            end
        end
    end

    assign initBusy   = (state == S_INIT);
    assign initIndex  = (state == S_INIT) ? counter : '0;
    assign fetchValid = (state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            counter <= '0;
        end else if (rstStart) begin
            state   <= S_INIT;
            counter <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    counter <= counter + 1'b1;
                    if (counter == IDX_W'(INIT_CYCLES - 1))
                        state <= S_BOOT;
                end
                S_BOOT:  state <= S_RUN;
                default: state <= state;
            endcase
        end
    end

    // Pending buffer: any stall=0 RUN cycle either consumes it or a fresh
    // redirect overrides it, so it always empties then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_kind  <= KIND_BR;
            pend_pc    <= '0;
            pend_hist  <= '0;
        end else if (rstStart) begin
            pend_valid <= 1'b0;
        end else if (state == S_RUN) begin
            if (!stall) begin
                pend_valid <= 1'b0;
            end else if (interruptAddrWE) begin
                pend_valid <= 1'b1;
                pend_kind  <= KIND_INT;
                pend_pc    <= interruptAddrIn;
                pend_hist  <= '0;
            end else if (br_hit && !(pend_valid && pend_kind == KIND_INT)) begin
                pend_valid <= 1'b1;
                pend_kind  <= KIND_BR;
                pend_pc    <= br_pc;
                pend_hist  <= br_hist;
            end
        end
    end

endmodule

// File: tb/tb_next_pc_redirect_arbiter.sv
// tb/tb_next_pc_redirect_arbiter.sv - self-checking bench for next_pc_redirect_arbiter
module tb_next_pc_redirect_arbiter;

    localparam int IW = 2;
    localparam int PW = 32;
    localparam int HW = 10;
    localparam int IC = 8;
    localparam logic [31:0] RV = 32'h0000_1000;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst;
    logic rstStart, stall;
    logic [PW-1:0] pcOut;
    logic [IW-1:0] brValid, brMispred;
    logic [IW*PW-1:0] brTarget;
    logic [IW*HW-1:0] brHistory;
    logic interruptAddrWE;
    logic [PW-1:0] interruptAddrIn;
    logic predValid;
    logic [PW-1:0] predNextPC;
    logic pcWE;
    logic [PW-1:0] pcIn;
    logic recoverBrHistory;
    logic [HW-1:0] recoveredBrHistory;
    logic initBusy;
    logic [2:0] initIndex;
    logic fetchValid;

    next_pc_redirect_arbiter #(
        .ISSUE_WIDTH(IW), .PC_WIDTH(PW), .HIST_WIDTH(HW),
        .INIT_CYCLES(IC), .RESET_VECTOR(RV), .FETCH_BYTES(FB)
    ) dut (
        .clk(clk), .rst(rst), .rstStart(rstStart), .stall(stall), .pcOut(pcOut),
        .brValid(brValid), .brMispred(brMispred), .brTarget(brTarget),
        .brHistory(brHistory), .interruptAddrWE(interruptAddrWE),
        .interruptAddrIn(interruptAddrIn), .predValid(predValid),
        .predNextPC(predNextPC), .pcWE(pcWE), .pcIn(pcIn),
        .recoverBrHistory(recoverBrHistory), .recoveredBrHistory(recoveredBrHistory),
        .initBusy(initBusy), .initIndex(initIndex), .fetchValid(fetchValid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: phase 0=idle 1=init 2=boot 3=run, plus a held redirect.
    int          m_phase;
    int          m_cnt;
    bit          m_hold;
    bit          m_hold_is_int;
    logic [PW-1:0] m_hold_pc;
    logic [HW-1:0] m_hold_hist;

    logic          e_we, e_rec, e_busy, e_fv;
    logic [PW-1:0] e_pc;
    logic [HW-1:0] e_hist;
    logic [2:0]    e_idx;

    task automatic model_comb();
        bit found;
        logic [PW-1:0] bp;
        logic [HW-1:0] bh;
        found = 0; bp = '0; bh = '0;
        for (int i = 0; i < IW; i++) begin
            if (!found && brValid[i] && brMispred[i]) begin
                found = 1;
                bp = brTarget[i*PW +: PW];
                bh = brHistory[i*HW +: HW];
            end
        end
        e_we = 0; e_pc = '0; e_rec = 0; e_hist = '0;
        e_busy = (m_phase == 1);
        e_idx  = (m_phase == 1) ? 3'(m_cnt) : 3'd0;
        e_fv   = (m_phase == 3);
        if (!rstStart && m_phase == 2) begin
            e_we = 1; e_pc = RV;
        end else if (!rstStart && m_phase == 3 && !stall) begin
            e_we = 1;
            if (interruptAddrWE) e_pc = interruptAddrIn;
            else if (found) begin e_pc = bp; e_rec = 1; e_hist = bh; end
            else if (m_hold) begin
                e_pc = m_hold_pc;
                if (!m_hold_is_int) begin e_rec = 1; e_hist = m_hold_hist; end
            end
            else if (predValid) e_pc = predNextPC;
            else e_pc = pcOut + 32'd8;
        end
    endtask

    task automatic model_clk();
        bit found;
        logic [PW-1:0] bp;
        logic [HW-1:0] bh;
        found = 0; bp = '0; bh = '0;
        for (int i = 0; i < IW; i++) begin
            if (!found && brValid[i] && brMispred[i]) begin
                found = 1;
                bp = brTarget[i*PW +: PW];
                bh = brHistory[i*HW +: HW];
            end
        end
        if (rstStart) begin
            m_phase = 1; m_cnt = 0; m_hold = 0;
        end else if (m_phase == 1) begin
            if (m_cnt == IC - 1) m_phase = 2;
            m_cnt = m_cnt + 1;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end else if (m_phase == 3) begin
            if (!stall) m_hold = 0;
            else if (interruptAddrWE) begin
                m_hold = 1; m_hold_is_int = 1; m_hold_pc = interruptAddrIn; m_hold_hist = '0;
            end else if (found && !(m_hold && m_hold_is_int)) begin
                m_hold = 1; m_hold_is_int = 0; m_hold_pc = bp; m_hold_hist = bh;
            end
        end
    endtask

    // Advance one clock, keeping the model and the emulated PC register in step.
    task automatic advance();
        logic          we;
        logic [PW-1:0] pc;
        model_comb();
        we = e_we; pc = e_pc;
        @(posedge clk);
        model_clk();
        #1;
        if (we) pcOut = pc;
    endtask

    task automatic quiet();
        rstStart = 0; stall = 0; brValid = '0; brMispred = '0;
        brTarget = '0; brHistory = '0; interruptAddrWE = 0;
        interruptAddrIn = '0; predValid = 0; predNextPC = '0;
    endtask

    task automatic test_reset();
        quiet();
        pcOut = '0;
        rst = 0;
        m_phase = 0; m_cnt = 0; m_hold = 0; m_hold_is_int = 0;
        m_hold_pc = '0; m_hold_hist = '0;
        #12;
        total++;
        if ({pcWE, pcIn, recoverBrHistory, recoveredBrHistory, initBusy, initIndex, fetchValid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got we=%0b pc=%h rec=%0b busy=%0b idx=%0d fv=%0b want all 0",
                     pcWE, pcIn, recoverBrHistory, initBusy, initIndex, fetchValid);
        end
        @(posedge clk); #1;
        rst = 1;
        advance();
        total++;
        if (pcWE !== 1'b0 || fetchValid !== 1'b0 || initBusy !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs got we=%0b fv=%0b busy=%0b want 0 0 0", pcWE, fetchValid, initBusy);
        end
    endtask

    task automatic test_init_walk();
        rstStart = 1;
        @(negedge clk);
        total++;
        if (pcWE !== 1'b0) begin bad++; $display("FAIL init_start_we got %0b want 0", pcWE); end
        advance();
        rstStart = 0;
        for (int i = 0; i < IC; i++) begin
            @(negedge clk);
            total++;
            if (initBusy !== 1'b1 || initIndex !== 3'(i) || pcWE !== 1'b0 || fetchValid !== 1'b0) begin
                bad++;
                $display("FAIL init_walk[%0d] got busy=%0b idx=%0d we=%0b fv=%0b want 1 %0d 0 0",
                         i, initBusy, initIndex, pcWE, fetchValid, i);
            end
            advance();
        end
        @(negedge clk);
        total++;
        if (pcWE !== 1'b1 || pcIn !== 32'h0000_1000 || initBusy !== 1'b0 || fetchValid !== 1'b0) begin
            bad++;
            $display("FAIL boot got we=%0b pc=%h busy=%0b fv=%0b want 1 00001000 0 0", pcWE, pcIn, initBusy, fetchValid);
        end
        advance();
        @(negedge clk);
        total++;
        if (fetchValid !== 1'b1 || pcOut !== 32'h0000_1000) begin
            bad++;
            $display("FAIL run_entry got fv=%0b pcOut=%h want 1 00001000", fetchValid, pcOut);
        end
    endtask

    task automatic test_sequential();
        quiet();
        pcOut = 32'h2000;
        @(negedge clk);
        total++;
        if (pcWE !== 1'b1 || pcIn !== 32'h2008 || recoverBrHistory !== 1'b0) begin
            bad++; $display("FAIL seq got we=%0b pc=%h rec=%0b want 1 00002008 0", pcWE, pcIn, recoverBrHistory);
        end
        advance();
        pcOut = 32'hFFFF_FFF8;
        @(negedge clk);
        total++;
        if (pcIn !== 32'h0000_0000) begin bad++; $display("FAIL wrap got %h want 00000000", pcIn); end
        advance();
        predValid = 1; predNextPC = 32'h4440;
        @(negedge clk);
        total++;
        if (pcIn !== 32'h4440) begin bad++; $display("FAIL pred got %h want 00004440", pcIn); end
        advance();
        quiet();
    endtask

    task automatic test_lane_priority();
        brValid = 2'b11; brMispred = 2'b11;
        brTarget = {32'h200, 32'h100};
        brHistory = {10'h22, 10'h11};
        predValid = 1; predNextPC = 32'h7770;
        @(negedge clk);
        total++;
        if (pcIn !== 32'h100 || recoverBrHistory !== 1'b1 || recoveredBrHistory !== 10'h11) begin
            bad++; $display("FAIL lane_pri got pc=%h rec=%0b hist=%h want 00000100 1 011", pcIn, recoverBrHistory, recoveredBrHistory);
        end
        advance();
        brMispred = 2'b10;
        @(negedge clk);
        total++;
        if (pcIn !== 32'h200 || recoveredBrHistory !== 10'h22) begin
            bad++; $display("FAIL lane1_only got pc=%h hist=%h want 00000200 022", pcIn, recoveredBrHistory);
        end
        advance();
        quiet();
    endtask

    task automatic test_stall_buffer();
        stall = 1; brValid = 2'b10; brMispred = 2'b10;
        brTarget = {32'h300, 32'h0}; brHistory = {10'h33, 10'h0};
        @(negedge clk);
        total++;
        if (pcWE !== 1'b0 || recoverBrHistory !== 1'b0) begin
            bad++; $display("FAIL stall_we got we=%0b rec=%0b want 0 0", pcWE, recoverBrHistory);
        end
        advance();
        brValid = '0; brMispred = '0;
        interruptAddrWE = 1; interruptAddrIn = 32'h800;
        advance();
        interruptAddrWE = 0;
        brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h400}; brHistory = {10'h0, 10'h44};
        advance();
        quiet();
        pcOut = 32'h5000;
        @(negedge clk);
        total++;
        if (pcWE !== 1'b1 || pcIn !== 32'h800 || recoverBrHistory !== 1'b0) begin
            bad++; $display("FAIL stall_release got we=%0b pc=%h rec=%0b want 1 00000800 0", pcWE, pcIn, recoverBrHistory);
        end
        advance();
        pcOut = 32'h5000;
        @(negedge clk);
        total++;
        if (pcIn !== 32'h5008) begin bad++; $display("FAIL buffer_drained got %h want 00005008", pcIn); end
        advance();
        stall = 1; brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h640}; brHistory = {10'h0, 10'h155};
        advance();
        quiet();
        @(negedge clk);
        total++;
        if (pcIn !== 32'h640 || recoverBrHistory !== 1'b1 || recoveredBrHistory !== 10'h155) begin
            bad++; $display("FAIL pend_branch got pc=%h rec=%0b hist=%h want 00000640 1 155", pcIn, recoverBrHistory, recoveredBrHistory);
        end
        advance();
    endtask

    task automatic test_int_vs_branch();
        interruptAddrWE = 1; interruptAddrIn = 32'h900;
        brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'hA00}; brHistory = {10'h0, 10'h3};
        @(negedge clk);
        total++;
        if (pcIn !== 32'h900 || recoverBrHistory !== 1'b0 || recoveredBrHistory !== 10'h0) begin
            bad++; $display("FAIL int_vs_br got pc=%h rec=%0b hist=%h want 00000900 0 000", pcIn, recoverBrHistory, recoveredBrHistory);
        end
        advance();
        quiet();
    endtask

    task automatic test_reinit();
        stall = 1; brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h500};
        advance();
        quiet();
        rstStart = 1;
        @(negedge clk);
        total++;
        if (pcWE !== 1'b0) begin bad++; $display("FAIL reinit_we got %0b want 0", pcWE); end
        advance();
        rstStart = 0;
        for (int i = 0; i < IC; i++) advance();
        @(negedge clk);
        total++;
        if (pcWE !== 1'b1 || pcIn !== 32'h1000) begin
            bad++; $display("FAIL reinit_boot got we=%0b pc=%h want 1 00001000", pcWE, pcIn);
        end
        advance();
        @(negedge clk);
        total++;
        if (pcIn !== 32'h1008 || recoverBrHistory !== 1'b0) begin
            bad++; $display("FAIL reinit_no_pend got pc=%h rec=%0b want 00001008 0", pcIn, recoverBrHistory);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rstStart = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 3) == 0);
            interruptAddrWE = ($urandom_range(0, 9) == 0);
            interruptAddrIn = $urandom & 32'hFFFF_FFFC;
            brValid = IW'($urandom);
            brMispred = ($urandom_range(0, 2) == 0) ? IW'($urandom) : '0;
            brTarget = {$urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC};
            brHistory = IW*HW'($urandom);
            predValid = ($urandom_range(0, 2) == 0);
            predNextPC = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            model_comb();
            total++;
            if (pcWE !== e_we || (e_we && pcIn !== e_pc) || recoverBrHistory !== e_rec ||
                recoveredBrHistory !== e_hist || initBusy !== e_busy || initIndex !== e_idx ||
                fetchValid !== e_fv) begin
                bad++;
                $display("FAIL rand[%0d] got we=%0b pc=%h rec=%0b hist=%h busy=%0b idx=%0d fv=%0b want %0b %h %0b %h %0b %0d %0b",
                         n, pcWE, pcIn, recoverBrHistory, recoveredBrHistory, initBusy, initIndex, fetchValid,
                         e_we, e_pc, e_rec, e_hist, e_busy, e_idx, e_fv);
            end
            advance();
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_init_walk();
        test_sequential();
        test_lane_priority();
        test_stall_buffer();
        test_int_vs_branch();
        test_reinit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
